// File: rtl/param_sram_ctrl.sv
// param_sram_ctrl: sequencer and arbiter for the EPU parameter SRAM.
// The single SRAM port is shared by a host write channel and an EPU read
// channel. On command, all parameter words are bulk-loaded into shadow
// registers that drive a flat configuration bus.
// Optional feature macro: PARAM_AUTO_LOAD_EN -- an in-range write to the last
// parameter address starts a bulk load on the next cycle.
// Reset rst is asynchronous and active-low.

module param_sram_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32,
    parameter int NUM_PARAM = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    // host write channel
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_err,
    // EPU read channel
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    // bulk load / configuration bus
    input  logic                          cmd_load,
    output logic                          busy,
    output logic                          cfg_valid,
    output logic [NUM_PARAM*DATA_W-1:0]   cfg_data,
    // SRAM port
    output logic                          mem_cs,
    output logic                          mem_oe,
    output logic                          mem_W_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_W_data,
    input  logic [DATA_W-1:0]             mem_R_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PARAM - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              oe_q;
    logic              rd_valid_q;
    logic              rd_oor_q;
    logic              wr_err_q;
    logic              cfg_valid_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [DATA_W-1:0] cfg_q [NUM_PARAM];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              cap_en;
    logic [ADDR_W-1:0] cap_idx;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_PARAM));
    endfunction

    assign wr_in_range = in_range(wr_addr);
    assign rd_in_range = in_range(rd_addr);

    // Next-state logic, IDLE arbitration and SRAM port drive.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        wr_ready   = 1'b0;
        rd_gnt     = 1'b0;
        mem_cs     = 1'b0;
        mem_W_req  = 1'b1;
        mem_addr   = '0;
        mem_W_data = '0;
        unique case (state_q)
            IDLE: begin
                // Nothing is granted while reset is held.
                if (rst) begin
                    if (cmd_load) begin
                        state_d = LOAD;
                    end else if (wr_valid) begin
                        wr_ready = 1'b1;
                        if (wr_in_range) begin
                            mem_cs     = 1'b1;
                            mem_W_req  = 1'b0;
                            mem_addr   = wr_addr;
                            mem_W_data = wr_data;
`ifdef PARAM_AUTO_LOAD_EN
                            if (wr_addr == LAST_ADDR) begin
                                state_d = LOAD;
                            end
`endif
                        end
                    end else if (rd_req) begin
                        rd_gnt = 1'b1;
                        if (rd_in_range) begin
                            mem_cs   = 1'b1;
                            mem_addr = rd_addr;
                        end
                    end
                end
            end
            LOAD: begin
                mem_cs   = 1'b1;
                mem_addr = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow capture slot: LOAD cycle k stores word k-1, DRAIN stores the last word.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = cnt_q;
        if (state_q == LOAD && cnt_q != '0) begin
            cap_en  = 1'b1;
            cap_idx = cnt_q - ADDR_W'(1);
        end else if (state_q == DRAIN) begin
            cap_en  = 1'b1;
        end
    end

    // State register, load counter and read/write side-band flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            oe_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_oor_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            cfg_valid_q <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            oe_q       <= mem_cs && mem_W_req;
            rd_valid_q <= rd_gnt;
            rd_oor_q   <= rd_gnt && !rd_in_range;
            wr_err_q   <= wr_ready && !wr_in_range;
            if (state_q == LOAD && cnt_q != LAST_ADDR) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end else if (state_q == IDLE) begin
                cnt_q <= '0;
            end
            if (rd_valid_q) begin
                rd_hold_q <= rd_data;
            end
            if (wr_ready && wr_in_range) begin
                cfg_valid_q <= 1'b0;
            end else if (state_q == DRAIN) begin
                cfg_valid_q <= 1'b1;
            end
        end
    end

    // Shadow registers filled from the SRAM read pipeline during a bulk load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this small register array is reset because cfg_data must read zero after reset.
            for (int i = 0; i < NUM_PARAM; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (cap_en) begin
            for (int i = 0; i < NUM_PARAM; i++) begin
                if (cap_idx == ADDR_W'(i)) begin
                    cfg_q[i] <= mem_R_data;
                end
            end
        end
    end

    // Read data is live in the rd_valid cycle, then held until the next read.
    always_comb begin
        rd_data = rd_hold_q;
        if (rd_valid_q) begin
            rd_data = rd_oor_q ? '0 : mem_R_data;
        end
    end

    // Flatten the shadow registers onto the configuration bus.
    always_comb begin
        cfg_data = '0;
        for (int i = 0; i < NUM_PARAM; i++) begin
            cfg_data[i*DATA_W +: DATA_W] = cfg_q[i];
        end
    end

    assign mem_oe    = oe_q;
    assign rd_valid  = rd_valid_q;
    assign wr_err    = wr_err_q;
    assign busy      = (state_q != IDLE);
    assign cfg_valid = cfg_valid_q;

endmodule
